// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy-segment bit reader.
package jpeg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_UNPACK,
    ST_DONE
  } word_state_e;

  localparam logic [7:0] BYTE_FF = 8'hFF;
  localparam logic [7:0] BYTE_00 = 8'h00;

  localparam int BUF_W_DEF       = 64;
  localparam int MAX_CONSUME_DEF = 16;
endpackage

// File: rtl/jpeg_byte_unstuffer.sv
// Byte-stuffing removal: drops 0x00 after 0xFF and flags marker bytes.
module jpeg_byte_unstuffer
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_fire,
  input  logic [7:0] byte_in,
  input  logic       byte_full,
  output logic       drop,
  output logic       marker_err
);

  logic prev_ff_q, prev_ff_d;
  logic marker_q, marker_d;

  always_comb begin
    drop      = prev_ff_q && byte_full && (byte_in == BYTE_00);
    prev_ff_d = prev_ff_q;
    marker_d  = marker_q;
    if (byte_fire) begin
      prev_ff_d = byte_full && (byte_in == BYTE_FF);
      if (prev_ff_q && (byte_in != BYTE_00))
        marker_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ff_q <= 1'b0;
      marker_q  <= 1'b0;
    end else begin
      prev_ff_q <= prev_ff_d;
      marker_q  <= marker_d;
    end
  end

  assign marker_err = marker_q;

endmodule

// File: rtl/jpeg_bit_reader.sv
// Unpacks stuffed 32-bit JPEG words into an MSB-aligned bit buffer
// from which the consumer removes 1..MAX_CONSUME bits per cycle.
module jpeg_bit_reader
  import jpeg_pkg::*;
#(
  parameter int BUF_W       = BUF_W_DEF,
  parameter int MAX_CONSUME = MAX_CONSUME_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] JPEG_bitstream,
  input  logic        data_ready,
  input  logic        eof_data_partial_ready,
  input  logic [4:0]  end_of_file_bitstream_count,
  output logic        in_ready,
  output logic [31:0] window,
  output logic [6:0]  bits_avail,
  input  logic        consume_valid,
  input  logic [4:0]  consume_len,
  output logic        stream_end,
  output logic        marker_err,
  output logic        underflow_err
);

  localparam logic [6:0] MAXC     = 7'(MAX_CONSUME);
  localparam logic [6:0] FILL_MAX = 7'(BUF_W - 8);

  word_state_e       state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [3:0]        last_q, last_d;
  logic              eof_q, eof_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              under_q, under_d;

  logic [6:0]        len_ext, cons_amt, cnt_rem;
  logic              cons_ok, accept, stall, fire;
  logic              is_last, full, drop;
  logic [3:0]        blen;
  logic [7:0]        byte_raw, byte_m;
  logic [BUF_W-1:0]  byte_ext;
  logic [2:0]        ebytes;
  logic [3:0]        elast;

  always_comb begin
    case (idx_q)
      2'd0:    byte_raw = word_q[31:24];
      2'd1:    byte_raw = word_q[23:16];
      2'd2:    byte_raw = word_q[15:8];
      default: byte_raw = word_q[7:0];
    endcase
    is_last = ({1'b0, idx_q} == (nbytes_q - 3'd1));
    blen    = is_last ? last_q : 4'd8;
    full    = (blen == 4'd8);
    // Zero the don't-care tail of a partial final byte
    byte_m  = byte_raw & ~(8'hFF >> blen);
    ebytes  = 3'(({1'b0, end_of_file_bitstream_count} + 6'd7) >> 3);
    elast   = (end_of_file_bitstream_count[2:0] == 3'd0) ? 4'd8
            : {1'b0, end_of_file_bitstream_count[2:0]};
  end

  always_comb begin
    len_ext  = {2'b00, consume_len};
    cons_ok  = consume_valid && (len_ext != 7'd0) &&
               (len_ext <= MAXC) && (len_ext <= cnt_q);
    cons_amt = cons_ok ? len_ext : 7'd0;
    cnt_rem  = cnt_q - cons_amt;
    stall    = (cnt_rem > FILL_MAX);
    fire     = (state_q == ST_UNPACK) && !stall;
    accept   = (state_q == ST_EMPTY) &&
               (data_ready || eof_data_partial_ready);
  end

  jpeg_byte_unstuffer u_unstuff (
    .clk        (clk),
    .rst        (rst),
    .byte_fire  (fire),
    .byte_in    (byte_m),
    .byte_full  (full),
    .drop       (drop),
    .marker_err (marker_err)
  );

  always_comb begin
    byte_ext = '0;
    byte_ext[BUF_W-1 -: 8] = byte_m;
    buf_d   = buf_q << cons_amt;
    cnt_d   = cnt_rem;
    under_d = under_q | (consume_valid && !cons_ok);
    if (fire && !drop) begin
      buf_d = buf_d | (byte_ext >> cnt_rem);
      cnt_d = cnt_rem + {3'b000, blen};
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    nbytes_d = nbytes_q;
    last_d   = last_q;
    eof_d    = eof_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          word_d = JPEG_bitstream;
          idx_d  = 2'd0;
          if (eof_data_partial_ready) begin
            eof_d    = 1'b1;
            nbytes_d = ebytes;
            last_d   = elast;
            state_d  = (end_of_file_bitstream_count == 5'd0)
                     ? ST_DONE : ST_UNPACK;
          end else begin
            eof_d    = 1'b0;
            nbytes_d = 3'd4;
            last_d   = 4'd8;
            state_d  = ST_UNPACK;
          end
        end
      end
      ST_UNPACK: begin
        if (fire) begin
          if (is_last) state_d = eof_q ? ST_DONE : ST_EMPTY;
          else         idx_d   = idx_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      word_q   <= '0;
      idx_q    <= '0;
      nbytes_q <= '0;
      last_q   <= '0;
      eof_q    <= 1'b0;
      buf_q    <= '0;
      cnt_q    <= '0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
      eof_q    <= eof_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      under_q  <= under_d;
    end
  end

  always_comb begin
    in_ready      = (state_q == ST_EMPTY);
    stream_end    = (state_q == ST_DONE);
    window        = buf_q[BUF_W-1 -: 32];
    bits_avail    = cnt_q;
    underflow_err = under_q;
  end

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed checks for jpeg_bit_reader: word table plus corner sequences.
module tb_jpeg_bit_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] JPEG_bitstream;
  logic        data_ready;
  logic        eof_data_partial_ready;
  logic [4:0]  end_of_file_bitstream_count;
  logic        in_ready;
  logic [31:0] window;
  logic [6:0]  bits_avail;
  logic        consume_valid;
  logic [4:0]  consume_len;
  logic        stream_end;
  logic        marker_err;
  logic        underflow_err;

  int n_total = 0;
  int n_pass  = 0;

  jpeg_bit_reader dut (
    .clk                         (clk),
    .rst                         (rst),
    .JPEG_bitstream              (JPEG_bitstream),
    .data_ready                  (data_ready),
    .eof_data_partial_ready      (eof_data_partial_ready),
    .end_of_file_bitstream_count (end_of_file_bitstream_count),
    .in_ready                    (in_ready),
    .window                      (window),
    .bits_avail                  (bits_avail),
    .consume_valid               (consume_valid),
    .consume_len                 (consume_len),
    .stream_end                  (stream_end),
    .marker_err                  (marker_err),
    .underflow_err               (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        eof;
    logic [4:0]  cnt;
    logic [6:0]  avail;
    logic [31:0] win;
    logic        mk;
    logic        fin;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_ready = 1'b0;
    eof_data_partial_ready = 1'b0;
    consume_valid = 1'b0;
    consume_len = 5'd0;
    JPEG_bitstream = '0;
    end_of_file_bitstream_count = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic e,
                      input logic [4:0] c);
    @(negedge clk);
    JPEG_bitstream = w;
    data_ready = !e;
    eof_data_partial_ready = e;
    end_of_file_bitstream_count = c;
    @(negedge clk);
    data_ready = 1'b0;
    eof_data_partial_ready = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready || stream_end) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic consume(input logic [4:0] n);
    @(negedge clk);
    consume_valid = 1'b1;
    consume_len = n;
    @(negedge clk);
    consume_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h12345678, 1'b0, 5'd0,  7'd32, 32'h12345678, 1'b0, 1'b0};
    tbl[1] = '{32'hFF00AB00, 1'b0, 5'd0,  7'd24, 32'hFFAB0000, 1'b0, 1'b0};
    tbl[2] = '{32'hABC00000, 1'b1, 5'd12, 7'd12, 32'hABC00000, 1'b0, 1'b1};
    tbl[3] = '{32'hFFD90000, 1'b0, 5'd0,  7'd32, 32'hFFD90000, 1'b1, 1'b0};
    tbl[4] = '{32'hFF000000, 1'b1, 5'd16, 7'd8,  32'hFF000000, 1'b0, 1'b1};
    tbl[5] = '{32'hFF0F0000, 1'b1, 5'd12, 7'd12, 32'hFF000000, 1'b0, 1'b1};
    tbl[6] = '{32'h12345678, 1'b1, 5'd0,  7'd0,  32'h00000000, 1'b0, 1'b1};
    tbl[7] = '{32'hFFFFFFFF, 1'b1, 5'd31, 7'd31, 32'hFFFFFFFE, 1'b1, 1'b1};

    rst = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_window", window, 32'h0);
    chk("rst_avail", 32'(bits_avail), 32'd0);
    chk("rst_end", 32'(stream_end), 32'd0);
    chk("rst_marker", 32'(marker_err), 32'd0);
    chk("rst_under", 32'(underflow_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(tbl[i].word, tbl[i].eof, tbl[i].cnt);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_avail", i), 32'(bits_avail), 32'(tbl[i].avail));
      chk($sformatf("v%0d_window", i), window, tbl[i].win);
      chk($sformatf("v%0d_marker", i), 32'(marker_err), 32'(tbl[i].mk));
      chk($sformatf("v%0d_end", i), 32'(stream_end), 32'(tbl[i].fin));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(!tbl[i].fin));
    end

    // Latency of first byte, then four 8-bit consumes
    do_reset();
    send(32'h12345678, 1'b0, 5'd0);
    chk("lat_before", 32'(bits_avail), 32'd0);
    @(negedge clk);
    chk("lat_avail", 32'(bits_avail), 32'd8);
    chk("lat_window", window, 32'h12000000);
    wait_done("c8");
    chk("c8_w0", window, 32'h12345678);
    consume(5'd8);
    chk("c8_w1", window, 32'h34567800);
    consume(5'd8);
    chk("c8_w2", window, 32'h56780000);
    consume(5'd8);
    chk("c8_w3", window, 32'h78000000);
    consume(5'd8);
    chk("c8_avail", 32'(bits_avail), 32'd0);
    chk("c8_under", 32'(underflow_err), 32'd0);

    // Stuffed zero dropped across a word boundary
    do_reset();
    send(32'h000000FF, 1'b0, 5'd0);
    wait_done("xw1");
    send(32'h00112233, 1'b0, 5'd0);
    wait_done("xw2");
    chk("xw_avail", 32'(bits_avail), 32'd56);
    chk("xw_window", window, 32'h000000FF);
    chk("xw_marker", 32'(marker_err), 32'd0);

    // Marker, then illegal consumes
    do_reset();
    send(32'hFFD90000, 1'b0, 5'd0);
    wait_done("mk");
    consume(5'd17);
    chk("over_max_avail", 32'(bits_avail), 32'd32);
    chk("over_max_under", 32'(underflow_err), 32'd1);
    do_reset();
    send(32'hFFD90000, 1'b0, 5'd0);
    wait_done("mk2");
    chk("mk_marker", 32'(marker_err), 32'd1);
    consume(5'd0);
    chk("zero_under", 32'(underflow_err), 32'd1);
    chk("zero_avail", 32'(bits_avail), 32'd32);

    // Stall at full buffer, then same-edge consume and append
    do_reset();
    send(32'h12345678, 1'b0, 5'd0);
    wait_done("st1");
    send(32'h9ABCDEF0, 1'b0, 5'd0);
    wait_done("st2");
    send(32'h11223344, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("stall_avail", 32'(bits_avail), 32'd64);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    consume(5'd8);
    chk("ca1_avail", 32'(bits_avail), 32'd64);
    chk("ca1_window", window, 32'h3456789A);
    consume(5'd16);
    chk("ca2_avail", 32'(bits_avail), 32'd56);
    chk("ca2_window", window, 32'h789ABCDE);

    // Reset in the middle of unpacking
    do_reset();
    consume(5'd20);
    chk("pre_under", 32'(underflow_err), 32'd1);
    send(32'hFFD91234, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_marker", 32'(marker_err), 32'd1);
    chk("pre_avail", 32'(bits_avail), 32'd16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_avail", 32'(bits_avail), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_marker", 32'(marker_err), 32'd0);
    chk("mid_under", 32'(underflow_err), 32'd0);
    chk("mid_window", window, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
